gauss3x3_stream: RTL and testbench

- Pipelined, parametrised successor of the team's combinational 3x3 Gaussian (1-2-1 / 2-4-2 / 1-2-1, >>4) blur.
- Accepts one pre-assembled 3x3 window per beat for CHANNELS colour channels over a valid/ready handshake.
- Produces one filtered pixel per channel after 3 pipeline stages, with per-beat mode: truncating blur, rounding blur, bypass, or sharpen.
- Sits between the window generator and the dark-channel/transmission stages of the dehazing datapath.

---
 rtl/gauss_pkg.sv | 27 ++
 rtl/gauss_row_121.sv | 25 ++
 rtl/gauss3x3_stream.sv | 185 ++++++++++++++++++
 tb/tb_gauss3x3_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gauss_pkg                                                        |
// | Purpose : Shared constants for the pipelined 3x3 Gaussian stream filter:   |
// |           per-beat mode encoding, kernel normalisation shift, rounding     |
// |           bias and the column-sum width helper.                            |
// | Ports   : none (package)                                                   |
// | Revision: 1.0  initial pipelined release                                   |
// +----------------------------------------------------------------------------+
package gauss_pkg;

  localparam logic [1:0] MODE_BLUR_TRUNC = 2'd0;
  localparam logic [1:0] MODE_BLUR_ROUND = 2'd1;
  localparam logic [1:0] MODE_BYPASS     = 2'd2;
  localparam logic [1:0] MODE_SHARPEN    = 2'd3;

  // Kernel weights sum to 16, so normalisation is a 4-bit right shift.
  localparam int KERNEL_SHIFT = 4;
  localparam int ROUND_BIAS   = 8;

  // Width of the full 1-2-1 x 1-2-1 sum: max 16*(2^DATA_W-1).
  function automatic int sum_w(input int data_w);
    return data_w + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_row_121.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gauss_row_121                                                    |
// | Purpose : Combinational 1-2-1 weighted sum, w0 + 2*w1 + w2, widened by     |
// |           two bits so it never overflows. Used for the row sums and, with  |
// |           wider inputs, for the column combine.                            |
// | Ports   : w0, w1, w2  in  [IN_W-1:0]   three taps                          |
// |           sum         out [IN_W+1:0]   weighted sum                        |
// | Revision: 1.0  initial pipelined release                                   |
// +----------------------------------------------------------------------------+
module gauss_row_121 #(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0] w0,
  input  logic [IN_W-1:0] w1,
  input  logic [IN_W-1:0] w2,
  output logic [IN_W+1:0] sum
);

  always_comb begin
    sum = {2'b00, w0} + {1'b0, w1, 1'b0} + {2'b00, w2};
  end

endmodule
`default_nettype wire

// File: rtl/gauss3x3_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gauss3x3_stream                                                  |
// | Purpose : Three-stage valid/ready pipeline applying a 3x3 Gaussian kernel  |
// |           (1-2-1 / 2-4-2 / 1-2-1, >>4) to CHANNELS channels per beat, with |
// |           per-beat truncating blur, rounding blur, bypass or sharpen.      |
// | Ports   : clk, rst (async, active high)                                    |
// |           in_valid/in_ready/in_win/in_mode/in_tag   upstream beat          |
// |           out_valid/out_ready/out_pix/out_tag       downstream beat        |
// | Revision: 1.0  initial pipelined release                                   |
// +----------------------------------------------------------------------------+
module gauss3x3_stream
  import gauss_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int TAG_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [9*CHANNELS*DATA_W-1:0]   in_win,
  input  logic [1:0]                     in_mode,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_W-1:0]     out_pix,
  output logic [TAG_W-1:0]               out_tag
);

  localparam int ROW_W = DATA_W + 2;
  localparam int SUM_W = sum_w(DATA_W);
  localparam int RND_W = SUM_W + 1;
  localparam logic [RND_W-1:0] BIAS = RND_W'(ROUND_BIAS);

  // Stage valid bits and the ready chain (bubbles collapse).
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic ready1, ready2, ready3;

  // Stage 1: row sums, centre pixel, mode, tag.
  logic [CHANNELS-1:0][2:0][ROW_W-1:0] row_sum, row_d, row_q;
  logic [CHANNELS-1:0][DATA_W-1:0]     ctr_in, ctr1_d, ctr1_q;
  logic [1:0]                          mode1_d, mode1_q;
  logic [TAG_W-1:0]                    tag1_d, tag1_q;

  // Stage 2: truncated and rounded blur, centre, mode, tag.
  logic [CHANNELS-1:0][SUM_W-1:0]      col_sum;
  logic [CHANNELS-1:0][DATA_W-1:0]     bt_d, bt_q, br_d, br_q, ctr2_d, ctr2_q;
  logic [1:0]                          mode2_d, mode2_q;
  logic [TAG_W-1:0]                    tag2_d, tag2_q;

  // Stage 3: mode select into the output registers.
  logic [CHANNELS-1:0][DATA_W+1:0]     sharp;
  logic [CHANNELS-1:0][DATA_W-1:0]     pix_sel;
  logic [CHANNELS*DATA_W-1:0]          pix_d, pix_q;
  logic [TAG_W-1:0]                    tag3_d, tag3_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    for (genvar r = 0; r < 3; r++) begin : g_row
      gauss_row_121 #(.IN_W(DATA_W)) u_row (
        .w0  (in_win[(c*9 + r*3 + 0)*DATA_W +: DATA_W]),
        .w1  (in_win[(c*9 + r*3 + 1)*DATA_W +: DATA_W]),
        .w2  (in_win[(c*9 + r*3 + 2)*DATA_W +: DATA_W]),
        .sum (row_sum[c][r])
      );
    end
    assign ctr_in[c] = in_win[(c*9 + 4)*DATA_W +: DATA_W];

    // Column combine reuses the 1-2-1 adder on the registered row sums.
    gauss_row_121 #(.IN_W(ROW_W)) u_col (
      .w0  (row_q[c][0]),
      .w1  (row_q[c][1]),
      .w2  (row_q[c][2]),
      .sum (col_sum[c])
    );
  end

  always_comb begin
    ready3   = ~v3_q | out_ready;
    ready2   = ~v2_q | ready3;
    ready1   = ~v1_q | ready2;
    in_ready = ready1;
    v1_d     = ready1 ? in_valid : v1_q;
    v2_d     = ready2 ? v1_q     : v2_q;
    v3_d     = ready3 ? v2_q     : v3_q;
  end

  always_comb begin
    row_d   = row_q;
    ctr1_d  = ctr1_q;
    mode1_d = mode1_q;
    tag1_d  = tag1_q;
    if (in_valid && ready1) begin
      row_d   = row_sum;
      ctr1_d  = ctr_in;
      mode1_d = in_mode;
      tag1_d  = in_tag;
    end
  end

  always_comb begin
    bt_d    = bt_q;
    br_d    = br_q;
    ctr2_d  = ctr2_q;
    mode2_d = mode2_q;
    tag2_d  = tag2_q;
    if (v1_q && ready2) begin
      for (int c = 0; c < CHANNELS; c++) begin
        bt_d[c] = DATA_W'(col_sum[c] >> KERNEL_SHIFT);
        // One extra bit holds S+8; the shifted result still fits DATA_W.
        br_d[c] = DATA_W'(({1'b0, col_sum[c]} + BIAS) >> KERNEL_SHIFT);
      end
      ctr2_d  = ctr1_q;
      mode2_d = mode1_q;
      tag2_d  = tag1_q;
    end
  end

  always_comb begin
    sharp   = '0;
    pix_sel = '0;
    pix_d   = pix_q;
    tag3_d  = tag3_q;
    for (int c = 0; c < CHANNELS; c++) begin
      // 2*centre - BR in DATA_W+2 bits two's complement: top bit is sign,
      // next bit set (when positive) means the value exceeds full scale.
      sharp[c] = {1'b0, ctr2_q[c], 1'b0} - {2'b00, br_q[c]};
      case (mode2_q)
        MODE_BLUR_TRUNC: pix_sel[c] = bt_q[c];
        MODE_BLUR_ROUND: pix_sel[c] = br_q[c];
        MODE_BYPASS:     pix_sel[c] = ctr2_q[c];
        default: begin
          if (sharp[c][DATA_W+1])  pix_sel[c] = '0;
          else if (sharp[c][DATA_W]) pix_sel[c] = '1;
          else                     pix_sel[c] = sharp[c][DATA_W-1:0];
        end
      endcase
    end
    if (v2_q && ready3) begin
      pix_d  = pix_sel;
      tag3_d = tag2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      row_q   <= '0;
      ctr1_q  <= '0;
      mode1_q <= '0;
      tag1_q  <= '0;
      bt_q    <= '0;
      br_q    <= '0;
      ctr2_q  <= '0;
      mode2_q <= '0;
      tag2_q  <= '0;
      pix_q   <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      row_q   <= row_d;
      ctr1_q  <= ctr1_d;
      mode1_q <= mode1_d;
      tag1_q  <= tag1_d;
      bt_q    <= bt_d;
      br_q    <= br_d;
      ctr2_q  <= ctr2_d;
      mode2_q <= mode2_d;
      tag2_q  <= tag2_d;
      pix_q   <= pix_d;
      tag3_q  <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_pix   = pix_q;
  assign out_tag   = tag3_q;

endmodule
`default_nettype wire

// File: tb/tb_gauss3x3_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_gauss3x3_stream                                               |
// | Purpose : Self-checking bench for gauss3x3_stream: directed kernel cases,  |
// |           backpressure, back-to-back, randomized handshake traffic against |
// |           an arithmetic reference model, and asynchronous reset.           |
// | Ports   : none                                                             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_gauss3x3_stream;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int TW    = 2;
  localparam int WIN_W = 9*CH*DW;
  localparam int PIX_W = CH*DW;
  localparam int N_RAND = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] in_win;
  logic [1:0]       in_mode;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pix;
  logic [TW-1:0]    out_tag;

  always #5 clk = ~clk;

  gauss3x3_stream #(.DATA_W(DW), .CHANNELS(CH), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_win    (in_win),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [TW-1:0]    tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference: weighted sum with kernel weight (row weight)*(col weight),
  // then the mode rule in plain integer arithmetic.
  function automatic logic [PIX_W-1:0] ref_pix(input logic [WIN_W-1:0] win, input logic [1:0] mode);
    logic [PIX_W-1:0] r;
    int s, bt, br, ctr, v, px, wr, wc;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      ctr = 0;
      for (int p = 0; p < 9; p++) begin
        px = int'(win[(c*9+p)*DW +: DW]);
        wr = (p / 3 == 1) ? 2 : 1;
        wc = (p % 3 == 1) ? 2 : 1;
        s  = s + wr * wc * px;
        if (p == 4) ctr = px;
      end
      bt = s / 16;
      br = (s + 8) / 16;
      case (mode)
        2'd0:    v = bt;
        2'd1:    v = br;
        2'd2:    v = ctr;
        default: begin
          v = 2 * ctr - br;
          if (v < 0) v = 0;
          if (v > (1 << DW) - 1) v = (1 << DW) - 1;
        end
      endcase
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [WIN_W-1:0] win_uc(input int centre, input int rest);
    logic [WIN_W-1:0] w;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < 9; p++)
        w[(c*9+p)*DW +: DW] = (p == 4) ? centre[DW-1:0] : rest[DW-1:0];
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] win_seq();
    logic [WIN_W-1:0] w;
    int v;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < 9; p++) begin
        v = p + 1;
        w[(c*9+p)*DW +: DW] = v[DW-1:0];
      end
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int i = 0; i < 9*CH; i++) begin
      case ($urandom_range(0, 3))
        0:       w[i*DW +: DW] = '0;
        1:       w[i*DW +: DW] = '1;
        default: w[i*DW +: DW] = DW'($urandom);
      endcase
    end
    return w;
  endfunction

  // One clock: sample handshakes at the falling edge, log accepted beats
  // into the model queue, return the delivered beat, resume 1ns past posedge.
  task automatic tick(output bit acc, output bit dlv, output logic [PIX_W-1:0] op, output logic [TW-1:0] ot);
    @(negedge clk);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    op  = out_pix;
    ot  = out_tag;
    if (acc) q.push_back('{pix: ref_pix(in_win, in_mode), tag: in_tag});
    @(posedge clk);
    #1;
  endtask

  // Single beat through an empty pipe with out_ready high; lat counts clocks
  // from the accepting cycle to the delivering cycle (-1 if never delivered).
  task automatic send_one(input logic [WIN_W-1:0] win, input logic [1:0] mode, input logic [TW-1:0] tag,
                          output logic [PIX_W-1:0] pix, output logic [TW-1:0] otag, output int lat);
    bit acc, dlv;
    logic [PIX_W-1:0] op;
    logic [TW-1:0] ot;
    in_win = win; in_mode = mode; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; pix = '0; otag = '0; acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) tick(acc, dlv, op, ot);
    in_valid = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 10 && lat < 0; i++) begin
        tick(acc, dlv, op, ot);
        if (dlv) begin lat = i; pix = op; otag = ot; end
      end
    end
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_win = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pix !== '0) begin errors++; $display("FAIL reset_out_pix: got %h expected 0", out_pix); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [PIX_W-1:0] pix; logic [TW-1:0] tg; int lat;
    send_one(win_seq(), 2'd0, 2'd2, pix, tg, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency: got %0d expected 3", lat); end
    checks++; if (pix !== {CH{8'd5}}) begin errors++; $display("FAIL seq_trunc: got %h expected %h", pix, {CH{8'd5}}); end
    checks++; if (tg !== 2'd2) begin errors++; $display("FAIL seq_tag: got %0d expected 2", tg); end
  endtask

  task automatic test_blur_sharpen();
    // centre, rest, mode, expected
    int cen[7]  = '{255, 255, 3, 3, 200, 0,   100};
    int rst_v[7] = '{255, 255, 0, 0, 0,   255, 100};
    int md[7]   = '{0,   1,   0, 1, 3,   3,   3};
    int ex[7]   = '{255, 255, 0, 1, 255, 0,   100};
    logic [PIX_W-1:0] pix; logic [TW-1:0] tg; int lat;
    logic [DW-1:0] e;
    logic [1:0] m;
    for (int i = 0; i < 7; i++) begin
      m = md[i][1:0];
      e = ex[i][DW-1:0];
      send_one(win_uc(cen[i], rst_v[i]), m, TW'(i), pix, tg, lat);
      checks++;
      if (pix !== {CH{e}} || lat !== 3)
        begin errors++; $display("FAIL kernel_case%0d: got %h lat %0d expected %h lat 3", i, pix, lat, {CH{e}}); end
    end
  endtask

  task automatic test_bypass_channels();
    logic [WIN_W-1:0] w; logic [PIX_W-1:0] pix, ctr; logic [TW-1:0] tg; int lat;
    for (int k = 0; k < 2; k++) begin
      w = rand_win();
      for (int c = 0; c < CH; c++) ctr[c*DW +: DW] = w[(c*9+4)*DW +: DW];
      send_one(w, 2'd2, 2'd1, pix, tg, lat);
      checks++; if (pix !== ctr) begin errors++; $display("FAIL bypass%0d: got %h expected %h", k, pix, ctr); end
      send_one(w, 2'd1, 2'd3, pix, tg, lat);
      checks++; if (pix !== ref_pix(w, 2'd1)) begin errors++; $display("FAIL round_chan%0d: got %h expected %h", k, pix, ref_pix(w, 2'd1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIN_W-1:0] wins[5];
    logic [TW-1:0] tags[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] mds[5];
    logic [PIX_W-1:0] held, op; logic [TW-1:0] ot;
    bit acc, dlv, stable;
    int idx, got;
    exp_t e;
    for (int i = 0; i < 5; i++) begin wins[i] = rand_win(); mds[i] = 2'($urandom_range(0, 3)); end
    q.delete();
    out_ready = 1'b0; idx = 0; stable = 1'b1; held = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_win = wins[idx]; in_mode = mds[idx]; in_tag = tags[idx];
      tick(acc, dlv, op, ot);
      if (acc) idx++;
      if (i == 3) held = out_pix;
      if (i > 3 && (out_pix !== held || out_valid !== 1'b1)) stable = 1'b0;
    end
    checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
    checks++; if (!stable) begin errors++; $display("FAIL bp_out_stable: got %h expected %h held", out_pix, held); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
    got = 0;
    for (int i = 0; i < 30 && got < 5; i++) begin
      if (idx < 5) begin in_valid = 1'b1; in_win = wins[idx]; in_mode = mds[idx]; in_tag = tags[idx]; end
      else in_valid = 1'b0;
      tick(acc, dlv, op, ot);
      if (acc) idx++;
      if (dlv) begin
        e = q.pop_front();
        checks++;
        if (ot !== tags[got] || op !== e.pix)
          begin errors++; $display("FAIL bp_order%0d: got tag %0d pix %h expected tag %0d pix %h", got, ot, op, tags[got], e.pix); end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got); end
    q.delete();
  endtask

  task automatic test_back_to_back();
    bit acc, dlv; logic [PIX_W-1:0] op; logic [TW-1:0] ot;
    int nacc;
    q.delete(); out_ready = 1'b1; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_win = rand_win(); in_mode = 2'($urandom_range(0, 3)); in_tag = 2'(i);
      tick(acc, dlv, op, ot);
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    checks++; if (nacc !== 6) begin errors++; $display("FAIL b2b_throughput: got %0d expected 6", nacc); end
    for (int i = 0; i < 5; i++) tick(acc, dlv, op, ot);
    q.delete();
  endtask

  task automatic test_random();
    bit acc, dlv; logic [PIX_W-1:0] op; logic [TW-1:0] ot;
    int sent, got, cyc, bad;
    exp_t e;
    q.delete(); sent = 0; got = 0; cyc = 0; bad = 0; in_valid = 1'b0;
    while (got < N_RAND && cyc < 60000) begin
      if (!in_valid && sent < N_RAND && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1; in_win = rand_win(); in_mode = 2'($urandom_range(0, 3)); in_tag = TW'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc, dlv, op, ot);
      cyc++;
      if (acc) begin sent++; in_valid = 1'b0; end
      if (dlv) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          if (bad++ < 10) $display("FAIL rand_extra_beat: got %h with empty model, expected none", op);
        end else begin
          e = q.pop_front();
          if (op !== e.pix || ot !== e.tag) begin
            errors++;
            if (bad++ < 10) $display("FAIL rand_beat%0d: got %h/%0d expected %h/%0d", got, op, ot, e.pix, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc, dlv, op, ot);
      if (dlv) got++;
    end
    checks++; if (got !== N_RAND) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got, N_RAND); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_leftover: got %0d expected 0", q.size()); end
    q.delete();
  endtask

  task automatic test_reset_midflight();
    bit acc, dlv; logic [PIX_W-1:0] op, pix; logic [TW-1:0] ot, tg;
    logic [WIN_W-1:0] w;
    int nacc, lat;
    q.delete(); out_ready = 1'b0; nacc = 0;
    for (int i = 0; i < 6 && nacc < 3; i++) begin
      in_valid = 1'b1; in_win = rand_win(); in_mode = 2'd2; in_tag = 2'd3;
      tick(acc, dlv, op, ot);
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pix !== '0 || out_tag !== '0) begin errors++; $display("FAIL async_reset_data: got %h/%0d expected 0/0", out_pix, out_tag); end
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", in_ready); end
    w = rand_win();
    send_one(w, 2'd3, 2'd1, pix, tg, lat);
    checks++;
    if (lat !== 3 || pix !== ref_pix(w, 2'd3) || tg !== 2'd1)
      begin errors++; $display("FAIL post_reset_beat: got %h lat %0d expected %h lat 3", pix, lat, ref_pix(w, 2'd3)); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_blur_sharpen();
    test_bypass_channels();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
